cm0_ahb_ram_slv: RTL
====================

CM0_AHB_RAM_SLV -- requirements
Module: cm0_ahb_ram_slv

Interface
REQ-001 Parameter AW, default 12, word-address width; capacity is 2^AW 32-bit words (16 KB at default).
REQ-002 Parameter WAIT, default 0, range 0..3, number of wait states inserted per read or write data phase.
REQ-003 hclk  input  1  single clock; all state updates on its rising edge.
REQ-004 hreset_n  input  1  reset, asynchronous and active-low.
REQ-005 hsel_i  input  1  slave select from the AHB-Lite decoder.
REQ-006 haddr_i  input  32  AHB address; bits [AW+1:0] are used.
REQ-007 htrans_i  input  2  AHB transfer type; only bit 1 (NONSEQ/SEQ) qualifies a transfer.
REQ-008 hsize_i  input  3  AHB size: 0 byte, 1 halfword, 2 word.
REQ-009 hwrite_i  input  1  write not read.
REQ-010 hwdata_i  input  32  write data, valid in the data phase.
REQ-011 hready_i  input  1  bus-level ready, which qualifies address-phase sampling.
REQ-012 hrdata_o  output  32  read data.
REQ-013 hreadyout_o  output  1  slave ready.
REQ-014 hresp_o  output  1  error response.

Function
REQ-015 The block shall accept an address phase when hsel_i, htrans_i[1] and hready_i are all 1 at a rising edge, and shall register haddr_i, hsize_i and hwrite_i at that edge.
REQ-016 The block shall hold states IDLE, WAIT, ERR1 and ERR2. Transitions:
- Accepted valid access: to WAIT if WAIT>0, otherwise remain IDLE with a zero-wait data phase.
- WAIT: a counter loads WAIT-1; the block leaves WAIT when the counter reaches 0.
- Accepted invalid access: to ERR1, then ERR2, then IDLE.
REQ-017 The block shall drive hreadyout_o=0 in WAIT and ERR1, and hreadyout_o=1 in IDLE and ERR2.
REQ-018 The block shall drive hresp_o=1 in ERR1 and ERR2 only (the two-cycle AHB error response).
REQ-019 Read data shall be the memory word at the registered address, driven on hrdata_o in the data-phase cycle where hreadyout_o=1. hrdata_o shall be 0 in all other cycles.
REQ-020 Write data shall be sampled from hwdata_i in the data-phase cycle where hreadyout_o=1 and written at that edge, using little-endian byte lanes:
- Byte: lane haddr[1:0].
- Halfword: lanes {haddr[1],0} and {haddr[1],1}.
- Word: all four lanes.
REQ-021 A read in the address phase immediately following a write to the same word shall return the newly written bytes.
REQ-022 Accepted address phases during WAIT are impossible, because hready_i=0. An address phase coinciding with the final data-phase cycle shall be accepted (pipelined back-to-back transfers).
REQ-023 IDLE and BUSY transfers, and cycles with hsel_i=0, shall produce no data phase and shall leave hreadyout_o=1 and hresp_o=0.
REQ-024 In ERR1/ERR2 no memory write shall occur. An address phase accepted in the ERR2 cycle shall be processed normally.
REQ-025 Address bits above AW+1 shall be ignored: the address wraps modulo the capacity.

Reset
REQ-026 On hreset_n=0, the state shall go to IDLE, the counter to 0, hreadyout_o to 1, hresp_o to 0, hrdata_o to 0, and all registered address-phase controls to 0.
REQ-027 Reset asserted mid data phase shall discard the pending transfer; memory contents shall not be reset or altered.

Configuration
REQ-028 Macro CM0_AHB_RAM_ERR_EN.
- Defined: the following accesses shall be invalid and take the ERR1/ERR2 path with no write:
  - hsize_i>2;
  - halfword with haddr[0]=1;
  - word with haddr[1:0]!=0.
- Undefined: no access shall be invalid. hsize_i>2 is treated as word, low address bits are aligned down to the access size, and hresp_o is tied to 0.

Verification
REQ-029 WAIT=0: word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase has hreadyout_o=1 in one cycle; read returns 0xDEADBEEF.
REQ-030 WAIT=2: read of 0x20 -> hreadyout_o low for exactly 2 cycles, then high with stored data.
REQ-031 Word 0x11223344 at 0x0, then byte write 0xAA to 0x2, then word read 0x0 -> 0x11AA3344.
REQ-032 ERR_EN defined: word write to 0x6 -> hresp_o=1/hreadyout_o=0, then hresp_o=1/hreadyout_o=1, and memory is unchanged. ERR_EN undefined: the same write updates word 0x4 with OKAY.
REQ-033 Back-to-back write 0x4 then read 0x4 with WAIT=0 -> read returns the write data with no bubble.
REQ-034 hreset_n pulsed low during a WAIT=3 read -> outputs go to reset values asynchronously; the next read completes normally and prior memory contents are intact.

Source files
------------

// File: rtl/cm0_ahb_ram_slv.sv
// cm0_ahb_ram_slv: AHB-Lite SRAM slave, 2^AW words, WAIT wait states per data phase.
// Define CM0_AHB_RAM_ERR_EN to answer oversized or misaligned accesses with an ERROR response.
module cm0_ahb_ram_slv #(
   parameter int AW   = 12,
   parameter int WAIT = 0
) (
   input  logic        hclk,
   input  logic        hreset_n,
   input  logic        hsel_i,
   input  logic [31:0] haddr_i,
   input  logic [1:0]  htrans_i,
   input  logic [2:0]  hsize_i,
   input  logic        hwrite_i,
   input  logic [31:0] hwdata_i,
   input  logic        hready_i,
   output logic [31:0] hrdata_o,
   output logic        hreadyout_o,
   output logic        hresp_o
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [1:0]    size_q, size_d;
   logic          write_q, write_d;
   logic [31:0]   mem [2**AW];
   logic          accept, invalid, dphase_end, unused;
   logic [1:0]    size_eff;
   logic [AW+1:0] addr_al;
   logic [3:0]    be;

   assign unused      = ^{haddr_i[31:AW+2], htrans_i[0]};
   assign hreadyout_o = state_q == S_IDLE || state_q == S_ERR2;
   assign accept      = hsel_i & htrans_i[1] & hready_i & hreadyout_o;
   assign dphase_end  = pend_q & (state_q == S_IDLE);
   assign size_eff    = hsize_i > 3'd2 ? 2'd2 : hsize_i[1:0];
   assign addr_al     = size_eff == 2'd2 ? {haddr_i[AW+1:2], 2'b00} :
                        size_eff == 2'd1 ? {haddr_i[AW+1:1], 1'b0} : haddr_i[AW+1:0];
   assign hrdata_o    = dphase_end & ~write_q ? mem[addr_q[AW+1:2]] : 32'h0;
   assign be          = size_q == 2'd2 ? 4'hf : size_q == 2'd1 ? (addr_q[1] ? 4'hc : 4'h3) :
                        4'b0001 << addr_q[1:0];

`ifdef CM0_AHB_RAM_ERR_EN
   assign invalid = hsize_i > 3'd2 || (hsize_i == 3'd1 && haddr_i[0]) ||
                    (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00);
   assign hresp_o = state_q == S_ERR1 || state_q == S_ERR2;
`else
   assign invalid = 1'b0;
   assign hresp_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;
      if (accept) begin
         addr_d  = addr_al;
         size_d  = size_eff;
         write_d = hwrite_i;
         pend_d  = ~invalid;
         state_d = invalid ? S_ERR1 : WAIT > 0 ? S_WAIT : S_IDLE;
         cnt_d   = WAIT > 0 ? 2'(WAIT - 1) : 2'd0;
      end else begin
         unique case (state_q)
            S_IDLE:  pend_d = 1'b0;
            S_WAIT: begin
               state_d = cnt_q == 2'd0 ? S_IDLE : S_WAIT;
               cnt_d   = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         pend_q  <= 1'b0;
         addr_q  <= '0;
         size_q  <= 2'd0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   // Memory has no reset; pend_q is cleared by reset so no write can slip through.
   always_ff @(posedge hclk) begin
      if (dphase_end & write_q)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= hwdata_i[8*b +: 8];
   end
endmodule
